// File: rtl/LOAD_STORE_FNS.sv
`default_nettype none
//------------------------------------------------------------------
// LOAD_STORE_FNS: funct3 encodings shared by RV32I loads/stores. Rev 1.0
//------------------------------------------------------------------
package LOAD_STORE_FNS;

  // Byte/half/word widths; the unsigned variants only exist for loads.
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_t;

endpackage
`default_nettype wire

// File: rtl/rv32i_opcodes.sv
`default_nettype none
//------------------------------------------------------------------
// rv32i_opcodes: opcode map and datapath control select types. Rev 1.0
//------------------------------------------------------------------
package rv32i_opcodes;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } rv32i_opcode_t;

  typedef enum logic [1:0] {
    FROM_ALU       = 2'd0,
    FROM_MEM       = 2'd1,
    FROM_PC_PLUS_4 = 2'd2
  } regfile_sel_t;

  typedef enum logic [2:0] {
    RST    = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PC_PLUS_4  = 2'd0,
    BRANCH_TGT = 2'd1,
    ALU_OUT    = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    RS1  = 2'd0,
    PC   = 2'd1,
    ZERO = 2'd2
  } alu_src_a_t;

  typedef enum logic [1:0] {
    FORCE_ADD  = 2'd0,
    FUNCT      = 2'd1,
    BRANCH_CMP = 2'd2
  } alu_op_t;

  typedef enum logic [3:0] {
    CLS_ILLEGAL  = 4'd0,
    CLS_OP       = 4'd1,
    CLS_OP_IMM   = 4'd2,
    CLS_LUI      = 4'd3,
    CLS_AUIPC    = 4'd4,
    CLS_LOAD     = 4'd5,
    CLS_STORE    = 4'd6,
    CLS_JAL      = 4'd7,
    CLS_JALR     = 4'd8,
    CLS_BRANCH   = 4'd9,
    CLS_MISC_MEM = 4'd10,
    CLS_SYSTEM   = 4'd11
  } instr_class_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------
// multicycle_ctrl_if: IR fields, memory handshake and datapath selects. Rev 1.0
//------------------------------------------------------------------
interface multicycle_ctrl_if;
  import rv32i_opcodes::*;

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic         branch_taken;
  logic         mem_ready;
  logic         mem_req;
  logic         mem_we;
  logic         mem_addr_sel;
  logic         ir_we;
  logic         pc_we;
  pc_sel_t      pc_sel;
  alu_src_a_t   alu_src_a;
  logic         alu_src_b;
  alu_op_t      alu_op;
  logic         regfile_we;
  regfile_sel_t regfile_sel;
  logic         halted;
  logic         illegal;

  modport master (
    input  opcode, funct3, branch_taken, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
           alu_src_a, alu_src_b, alu_op, regfile_we, regfile_sel,
           halted, illegal
  );

  modport slave (
    output opcode, funct3, branch_taken, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
           alu_src_a, alu_src_b, alu_op, regfile_we, regfile_sel,
           halted, illegal
  );

endinterface
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
//------------------------------------------------------------------
// ctrl_decode: opcode/funct3 to instruction class and legality. Rev 1.0
//------------------------------------------------------------------
module ctrl_decode
  import rv32i_opcodes::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  output instr_class_t instr_class,
  output logic         legal
);

  LOAD_STORE_FNS::funct3_t ls_fn;
  assign ls_fn = LOAD_STORE_FNS::funct3_t'(funct3);

  always_comb begin
    instr_class = CLS_ILLEGAL;
    legal       = 1'b0;
    case (rv32i_opcode_t'(opcode))
      OPC_LOAD: begin
        instr_class = CLS_LOAD;
        legal = ls_fn inside {LOAD_STORE_FNS::F3_B, LOAD_STORE_FNS::F3_H,
                              LOAD_STORE_FNS::F3_W, LOAD_STORE_FNS::F3_BU,
                              LOAD_STORE_FNS::F3_HU};
      end
      OPC_STORE: begin
        instr_class = CLS_STORE;
        legal = (funct3 <= LOAD_STORE_FNS::F3_W);
      end
      OPC_BRANCH: begin
        // funct3 010/011 are unassigned branch encodings
        instr_class = CLS_BRANCH;
        legal = !(funct3 inside {3'b010, 3'b011});
      end
      OPC_OP:       begin instr_class = CLS_OP;       legal = 1'b1; end
      OPC_OP_IMM:   begin instr_class = CLS_OP_IMM;   legal = 1'b1; end
      OPC_LUI:      begin instr_class = CLS_LUI;      legal = 1'b1; end
      OPC_AUIPC:    begin instr_class = CLS_AUIPC;    legal = 1'b1; end
      OPC_JAL:      begin instr_class = CLS_JAL;      legal = 1'b1; end
      OPC_JALR:     begin instr_class = CLS_JALR;     legal = 1'b1; end
      OPC_MISC_MEM: begin instr_class = CLS_MISC_MEM; legal = 1'b1; end
      OPC_SYSTEM:   begin instr_class = CLS_SYSTEM;   legal = 1'b1; end
      default: begin
        instr_class = CLS_ILLEGAL;
        legal       = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
//------------------------------------------------------------------
// multicycle_ctrl: RV32I fetch/decode/exec/mem/wb sequencing FSM. Rev 1.0
//------------------------------------------------------------------
module multicycle_ctrl
  import rv32i_opcodes::*;
(
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  ctrl_state_t  state;
  logic         illegal_latched;
  instr_class_t instr_class;
  logic         legal;

  ctrl_decode u_decode (
    .opcode      (bus.opcode),
    .funct3      (bus.funct3),
    .instr_class (instr_class),
    .legal       (legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= RST;
      illegal_latched <= 1'b0;
    end else begin
      case (state)
        RST:   state <= FETCH;
        FETCH: if (bus.mem_ready) state <= DECODE;
        DECODE: begin
          if (!legal) begin
            state           <= HALT;
            illegal_latched <= 1'b1;
          end else begin
            case (instr_class)
              CLS_SYSTEM:   state <= HALT;
              CLS_MISC_MEM: state <= FETCH;
              default:      state <= EXEC;
            endcase
          end
        end
        EXEC: begin
          case (instr_class)
            CLS_LOAD, CLS_STORE: state <= MEM;
            CLS_BRANCH:          state <= FETCH;
            default:             state <= WB;
          endcase
        end
        MEM: begin
          if (bus.mem_ready) state <= (instr_class == CLS_STORE) ? FETCH : WB;
        end
        WB:      state <= FETCH;
        HALT:    state <= HALT;
        default: state <= RST;
      endcase
    end
  end

  // Outputs follow the state (and mem_ready in FETCH/MEM) so zero-wait
  // memory completes a request in the same cycle it is issued.
  always_comb begin
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.pc_sel       = PC_PLUS_4;
    bus.alu_src_a    = RS1;
    bus.alu_src_b    = 1'b0;
    bus.alu_op       = FORCE_ADD;
    bus.regfile_we   = 1'b0;
    bus.regfile_sel  = FROM_ALU;
    bus.halted       = 1'b0;
    bus.illegal      = illegal_latched;
    case (state)
      FETCH: begin
        bus.mem_req = 1'b1;
        bus.ir_we   = bus.mem_ready;
      end
      DECODE: begin
        bus.pc_we = legal && (instr_class == CLS_MISC_MEM);
      end
      EXEC: begin
        case (instr_class)
          CLS_OP: bus.alu_op = FUNCT;
          CLS_OP_IMM: begin
            bus.alu_src_b = 1'b1;
            bus.alu_op    = FUNCT;
          end
          CLS_LUI: begin
            bus.alu_src_a = ZERO;
            bus.alu_src_b = 1'b1;
          end
          CLS_AUIPC, CLS_JAL: begin
            bus.alu_src_a = PC;
            bus.alu_src_b = 1'b1;
          end
          CLS_LOAD, CLS_STORE, CLS_JALR: bus.alu_src_b = 1'b1;
          CLS_BRANCH: begin
            bus.alu_op = BRANCH_CMP;
            bus.pc_we  = 1'b1;
            bus.pc_sel = bus.branch_taken ? BRANCH_TGT : PC_PLUS_4;
          end
          default: ;
        endcase
      end
      MEM: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        bus.mem_we       = (instr_class == CLS_STORE);
        bus.pc_we        = (instr_class == CLS_STORE) && bus.mem_ready;
      end
      WB: begin
        bus.regfile_we = 1'b1;
        bus.pc_we      = 1'b1;
        if (instr_class == CLS_LOAD) begin
          bus.regfile_sel = FROM_MEM;
        end else if (instr_class == CLS_JAL || instr_class == CLS_JALR) begin
          bus.regfile_sel = FROM_PC_PLUS_4;
          bus.pc_sel      = ALU_OUT;
        end
      end
      HALT:    bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
//------------------------------------------------------------------
// tb_multicycle_ctrl: table-driven scoreboard bench for multicycle_ctrl. Rev 1.0
//------------------------------------------------------------------
module tb_multicycle_ctrl;
  import rv32i_opcodes::*;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       regfile_we;
    logic [1:0] regfile_sel;
    logic       halted;
    logic       illegal;
  } out_t;

  typedef struct {
    logic  rdy;
    out_t  exp;
    string tag;
  } sb_t;

  typedef struct {
    string        name;
    logic [6:0]   op;
    logic [2:0]   f3;
    logic         taken;
    int           fw;
    int           mw;
    regfile_sel_t rsel;
    pc_sel_t      psel;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  sb_t  q[$];
  vec_t vecs[15];

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t a;
    a.mem_req      = bus.mem_req;
    a.mem_we       = bus.mem_we;
    a.mem_addr_sel = bus.mem_addr_sel;
    a.ir_we        = bus.ir_we;
    a.pc_we        = bus.pc_we;
    a.pc_sel       = bus.pc_sel;
    a.alu_src_a    = bus.alu_src_a;
    a.alu_src_b    = bus.alu_src_b;
    a.alu_op       = bus.alu_op;
    a.regfile_we   = bus.regfile_we;
    a.regfile_sel  = bus.regfile_sel;
    a.halted       = bus.halted;
    a.illegal      = bus.illegal;
    return a;
  endfunction

  task automatic check(input string tag, input out_t exp);
    out_t act;
    act = sample();
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic void push(input logic rdy, input out_t e, input string tag);
    sb_t r;
    r.rdy = rdy;
    r.exp = e;
    r.tag = tag;
    q.push_back(r);
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal_instr(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0000011: return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      7'b0100011: return f3 <= 3'd2;
      7'b1100011: return !(f3 inside {3'd2, 3'd3});
      7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111,
      7'b1101111, 7'b1100111, 7'b0001111, 7'b1110011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected per-cycle outputs of one instruction, from FETCH entry onward.
  function automatic void build(input vec_t v, input int halt_cycles);
    out_t o;
    logic ok;
    logic is_ls;
    for (int i = 0; i < v.fw; i++) begin
      o = '0; o.mem_req = 1'b1;
      push(1'b0, o, {v.name, " fetch-wait"});
    end
    o = '0; o.mem_req = 1'b1; o.ir_we = 1'b1;
    push(1'b1, o, {v.name, " fetch"});
    ok = legal_instr(v.op, v.f3);
    o = '0;
    if (!ok || v.op == 7'b1110011) begin
      push(rnd(), o, {v.name, " decode"});
      o.halted = 1'b1; o.illegal = !ok;
      for (int i = 0; i < halt_cycles; i++) push(rnd(), o, {v.name, " halt"});
      return;
    end
    if (v.op == 7'b0001111) begin
      o.pc_we = 1'b1;
      push(rnd(), o, {v.name, " decode"});
      return;
    end
    push(rnd(), o, {v.name, " decode"});
    o = '0;
    o.alu_src_b = 1'b1;
    case (v.op)
      7'b0110011: begin o.alu_src_b = 1'b0; o.alu_op = FUNCT; end
      7'b0010011: o.alu_op = FUNCT;
      7'b0110111: o.alu_src_a = ZERO;
      7'b0010111, 7'b1101111: o.alu_src_a = PC;
      7'b1100011: begin
        o.alu_src_b = 1'b0; o.alu_op = BRANCH_CMP; o.pc_we = 1'b1;
        o.pc_sel = v.taken ? BRANCH_TGT : PC_PLUS_4;
      end
      default: ;
    endcase
    push(rnd(), o, {v.name, " exec"});
    if (v.op == 7'b1100011) return;
    is_ls = (v.op == 7'b0000011) || (v.op == 7'b0100011);
    if (is_ls) begin
      o = '0; o.mem_req = 1'b1; o.mem_addr_sel = 1'b1;
      o.mem_we = (v.op == 7'b0100011);
      for (int i = 0; i < v.mw; i++) push(1'b0, o, {v.name, " mem-wait"});
      o.pc_we = (v.op == 7'b0100011);
      push(1'b1, o, {v.name, " mem"});
      if (v.op == 7'b0100011) return;
    end
    o = '0; o.regfile_we = 1'b1; o.pc_we = 1'b1;
    o.regfile_sel = v.rsel; o.pc_sel = v.psel;
    push(rnd(), o, {v.name, " wb"});
  endfunction

  task automatic drain();
    sb_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      bus.mem_ready = r.rdy;
      #1;
      check(r.tag, r.exp);
    end
  endtask

  task automatic run(input vec_t v, input int halt_cycles);
    @(posedge clk);
    #1;
    bus.opcode       = v.op;
    bus.funct3       = v.f3;
    bus.branch_taken = v.taken;
    build(v, halt_cycles);
    drain();
  endtask

  // A pending response (mem_ready=1) during reset must be ignored.
  task automatic do_reset(input int n);
    out_t z;
    z = '0;
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      check("reset", z);
    end
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    out_t o;
    vecs[0]  = '{"ADDI",  7'b0010011, 3'b000, 1'b0, 0, 0, FROM_ALU,       PC_PLUS_4};
    vecs[1]  = '{"ADD",   7'b0110011, 3'b000, 1'b0, 1, 0, FROM_ALU,       PC_PLUS_4};
    vecs[2]  = '{"LUI",   7'b0110111, 3'b000, 1'b0, 0, 0, FROM_ALU,       PC_PLUS_4};
    vecs[3]  = '{"AUIPC", 7'b0010111, 3'b000, 1'b0, 0, 0, FROM_ALU,       PC_PLUS_4};
    vecs[4]  = '{"JAL",   7'b1101111, 3'b000, 1'b0, 0, 0, FROM_PC_PLUS_4, ALU_OUT};
    vecs[5]  = '{"JALR",  7'b1100111, 3'b000, 1'b0, 0, 0, FROM_PC_PLUS_4, ALU_OUT};
    vecs[6]  = '{"LW",    7'b0000011, 3'b010, 1'b0, 2, 2, FROM_MEM,       PC_PLUS_4};
    vecs[7]  = '{"LB",    7'b0000011, 3'b000, 1'b0, 0, 0, FROM_MEM,       PC_PLUS_4};
    vecs[8]  = '{"LHU",   7'b0000011, 3'b101, 1'b0, 0, 1, FROM_MEM,       PC_PLUS_4};
    vecs[9]  = '{"SW",    7'b0100011, 3'b010, 1'b0, 0, 0, FROM_ALU,       PC_PLUS_4};
    vecs[10] = '{"SB",    7'b0100011, 3'b000, 1'b0, 1, 3, FROM_ALU,       PC_PLUS_4};
    vecs[11] = '{"BEQ-T", 7'b1100011, 3'b000, 1'b1, 0, 0, FROM_ALU,       PC_PLUS_4};
    vecs[12] = '{"BEQ-N", 7'b1100011, 3'b000, 1'b0, 0, 0, FROM_ALU,       PC_PLUS_4};
    vecs[13] = '{"BGEU",  7'b1100011, 3'b111, 1'b1, 1, 0, FROM_ALU,       PC_PLUS_4};
    vecs[14] = '{"FENCE", 7'b0001111, 3'b000, 1'b0, 0, 0, FROM_ALU,       PC_PLUS_4};

    bus.opcode = 7'd0;
    bus.funct3 = 3'd0;
    bus.branch_taken = 1'b0;
    bus.mem_ready = 1'b0;
    do_reset(2);

    for (int i = 0; i < 15; i++) run(vecs[i], 0);

    // Reset arriving while a load is parked in MEM with mem_req high.
    @(posedge clk);
    #1;
    bus.opcode = 7'b0000011;
    bus.funct3 = 3'b010;
    o = '0; o.mem_req = 1'b1; o.ir_we = 1'b1;
    push(1'b1, o, "rst-mid fetch");
    o = '0;
    push(1'b0, o, "rst-mid decode");
    o.alu_src_b = 1'b1;
    push(1'b0, o, "rst-mid exec");
    o = '0; o.mem_req = 1'b1; o.mem_addr_sel = 1'b1;
    push(1'b0, o, "rst-mid mem");
    drain();
    do_reset(3);
    run(vecs[0], 0);

    v = '{"ILL7F", 7'b1111111, 3'b000, 1'b0, 0, 0, FROM_ALU, PC_PLUS_4};
    run(v, 10);
    do_reset(1);
    v = '{"ECALL", 7'b1110011, 3'b000, 1'b0, 0, 0, FROM_ALU, PC_PLUS_4};
    run(v, 10);
    do_reset(1);
    v = '{"LD-F3", 7'b0000011, 3'b011, 1'b0, 0, 0, FROM_ALU, PC_PLUS_4};
    run(v, 3);
    do_reset(1);
    v = '{"ST-F3", 7'b0100011, 3'b011, 1'b0, 1, 0, FROM_ALU, PC_PLUS_4};
    run(v, 3);
    do_reset(1);
    v = '{"BR-F3", 7'b1100011, 3'b010, 1'b0, 0, 0, FROM_ALU, PC_PLUS_4};
    run(v, 3);
    do_reset(1);
    run(vecs[6], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
